// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, ALU codes and sequencer state types
package cpu_pkg;

  // Instruction opcodes (upper nibble of the instruction byte)
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_INC  = 4'h6;
  localparam logic [3:0] OP_DEC  = 4'h7;
  localparam logic [3:0] OP_SHR  = 4'h8;
  localparam logic [3:0] OP_LDI  = 4'h9;
  localparam logic [3:0] OP_NEG  = 4'hA;
  localparam logic [3:0] OP_STA  = 4'hB;
  localparam logic [3:0] OP_CLR  = 4'hC;
  localparam logic [3:0] OP_HALT = 4'hF;

  // ALU operation codes driven on alus
  localparam logic [3:0] ALU_ZERO = 4'h0;
  localparam logic [3:0] ALU_ADD  = 4'h1;
  localparam logic [3:0] ALU_SUB  = 4'h2;
  localparam logic [3:0] ALU_AND  = 4'h3;
  localparam logic [3:0] ALU_OR   = 4'h4;
  localparam logic [3:0] ALU_XOR  = 4'h5;
  localparam logic [3:0] ALU_INC  = 4'h6;
  localparam logic [3:0] ALU_DEC  = 4'h7;
  localparam logic [3:0] ALU_SHR  = 4'h8;
  localparam logic [3:0] ALU_PASS = 4'h9;
  localparam logic [3:0] ALU_NEG  = 4'hA;

  // Instruction classes produced by the decoder
  localparam logic [2:0] CLS_NOP   = 3'd0;
  localparam logic [2:0] CLS_BIN   = 3'd1;
  localparam logic [2:0] CLS_UNARY = 3'd2;
  localparam logic [2:0] CLS_STA   = 3'd3;
  localparam logic [2:0] CLS_HALT  = 3'd4;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    OPER   = 3'd2,
    EXEC   = 3'd3,
    STORE  = 3'd4,
    HALT   = 3'd5
  } state_t;

endpackage

// File: rtl/seq_decode.sv
// rtl/seq_decode.sv - combinational opcode decoder: class, ALU code, illegal flag
module seq_decode
  import cpu_pkg::*;
(
  input  logic [3:0] opcode,
  output logic [2:0] op_class,
  output logic [3:0] alu_op,
  output logic       is_illegal
);

  // Map each opcode to its class and ALU operation; D/E decode as illegal no-ops
  always_comb begin
    op_class   = CLS_NOP;
    alu_op     = ALU_ZERO;
    is_illegal = 1'b0;
    case (opcode)
      OP_NOP:  op_class = CLS_NOP;
      OP_ADD:  begin op_class = CLS_BIN;   alu_op = ALU_ADD;  end
      OP_SUB:  begin op_class = CLS_BIN;   alu_op = ALU_SUB;  end
      OP_AND:  begin op_class = CLS_BIN;   alu_op = ALU_AND;  end
      OP_OR:   begin op_class = CLS_BIN;   alu_op = ALU_OR;   end
      OP_XOR:  begin op_class = CLS_BIN;   alu_op = ALU_XOR;  end
      OP_LDI:  begin op_class = CLS_BIN;   alu_op = ALU_PASS; end
      OP_INC:  begin op_class = CLS_UNARY; alu_op = ALU_INC;  end
      OP_DEC:  begin op_class = CLS_UNARY; alu_op = ALU_DEC;  end
      OP_SHR:  begin op_class = CLS_UNARY; alu_op = ALU_SHR;  end
      OP_NEG:  begin op_class = CLS_UNARY; alu_op = ALU_NEG;  end
      OP_CLR:  begin op_class = CLS_UNARY; alu_op = ALU_ZERO; end
      OP_STA:  op_class = CLS_STA;
      OP_HALT: op_class = CLS_HALT;
      default: begin op_class = CLS_NOP;   is_illegal = 1'b1; end
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - fetch/decode/execute FSM driving the ALU; optional ILLEGAL_TRAP_EN
module alu_sequencer
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        opnd,
  output logic [3:0]        alus,
  output logic              acc_ld,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              illegal
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        ir_q, ir_d;      // only the opcode nibble is kept; the low nibble is ignored
  logic [7:0]        opnd_q, opnd_d;
  logic              illegal_q, illegal_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic              acc_ld_q, acc_ld_d;
  logic              halted_q, halted_d;
  logic [3:0]        alus_q, alus_d;

  logic [2:0]        op_class;
  logic [3:0]        alu_op;
  logic              is_illegal;
  logic              xfer;

  seq_decode u_decode (
    .opcode     (ir_q),
    .op_class   (op_class),
    .alu_op     (alu_op),
    .is_illegal (is_illegal)
  );

  assign xfer = mem_req_q && mem_ack;

  // State and datapath registers; reset abandons any outstanding transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      addr_q    <= '0;
      ir_q      <= '0;
      opnd_q    <= '0;
      illegal_q <= 1'b0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      acc_ld_q  <= 1'b0;
      halted_q  <= 1'b0;
      alus_q    <= ALU_ZERO;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      ir_q      <= ir_d;
      opnd_q    <= opnd_d;
      illegal_q <= illegal_d;
      mem_req_q <= mem_req_d;
      mem_we_q  <= mem_we_d;
      acc_ld_q  <= acc_ld_d;
      halted_q  <= halted_d;
      alus_q    <= alus_d;
    end
  end

  // Next state, program counter and operand capture
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    addr_d    = addr_q;
    ir_d      = ir_q;
    opnd_d    = opnd_q;
    illegal_d = illegal_q;
    case (state_q)
      FETCH: begin
        if (xfer) begin
          ir_d    = mem_rdata[7:4];
          pc_d    = pc_q + ADDR_W'(1);
          state_d = DECODE;
        end
      end
      DECODE: begin
        case (op_class)
          CLS_BIN, CLS_STA: state_d = OPER;
          CLS_UNARY:        state_d = EXEC;
          CLS_HALT:         state_d = HALT;
          default:          state_d = FETCH;
        endcase
        if (is_illegal) begin
`ifdef ILLEGAL_TRAP_EN
          illegal_d = 1'b1;
          state_d   = HALT;
`else
          state_d   = FETCH;
`endif
        end
      end
      OPER: begin
        if (xfer) begin
          pc_d = pc_q + ADDR_W'(1);
          if (op_class == CLS_STA) begin
            addr_d  = ADDR_W'(mem_rdata);
            state_d = STORE;
          end else begin
            opnd_d  = mem_rdata;
            state_d = EXEC;
          end
        end
      end
      EXEC:    state_d = FETCH;
      STORE:   if (xfer) state_d = FETCH;
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  // Registered outputs decoded from the next state; a pending fetch request is held until ack
  always_comb begin
    mem_req_d = 1'b0;
    mem_we_d  = 1'b0;
    acc_ld_d  = 1'b0;
    halted_d  = 1'b0;
    alus_d    = ALU_ZERO;
    case (state_d)
      FETCH:   mem_req_d = run || (state_q == FETCH && mem_req_q);
      OPER:    mem_req_d = 1'b1;
      STORE:   begin mem_req_d = 1'b1; mem_we_d = 1'b1; end
      EXEC:    begin acc_ld_d = 1'b1; alus_d = alu_op; end
      HALT:    halted_d = 1'b1;
      default: mem_req_d = 1'b0;
    endcase
  end

  assign mem_req  = mem_req_q;
  assign mem_we   = mem_we_q;
  assign mem_addr = (state_q == STORE) ? addr_q : pc_q;
  assign opnd     = opnd_q;
  assign alus     = alus_q;
  assign acc_ld   = acc_ld_q;
  assign pc       = pc_q;
  assign halted   = halted_q;
  assign illegal  = illegal_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed self-checking bench for alu_sequencer
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic       mem_req, mem_we, mem_ack = 1'b0;
  logic [7:0] mem_addr, mem_rdata = 8'h00;
  logic [7:0] opnd, pc;
  logic [3:0] alus;
  logic       acc_ld, halted, illegal;

  int checks = 0;
  int failures = 0;

  logic [7:0] mem [256];
  int         wait_cycles = 0;
  int         wcnt = 0;
  int         ack_cnt = 0;
  logic [7:0] ack_hist [3];
  int         wr_cnt = 0;
  logic [7:0] wr_addr = 8'h00;
  int         ld_cnt = 0;
  logic [3:0] ld_alus = 4'h0;
  logic [7:0] ld_opnd = 8'h00;
  logic [7:0] ld_pc = 8'h00;
  int         req_cycles = 0;

  alu_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .opnd      (opnd),
    .alus      (alus),
    .acc_ld    (acc_ld),
    .pc        (pc),
    .halted    (halted),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  // Memory responder with programmable wait states, plus accumulator-load and request monitors
  always @(negedge clk) begin
    if (!rst_n) begin
      mem_ack = 1'b0;
      wcnt = 0;
    end else begin
      if (mem_ack) begin
        mem_ack = 1'b0;
        wcnt = 0;
      end
      if (mem_req) begin
        if (wcnt >= wait_cycles) begin
          mem_ack = 1'b1;
          mem_rdata = mem[mem_addr];
          ack_hist[2] = ack_hist[1];
          ack_hist[1] = ack_hist[0];
          ack_hist[0] = mem_addr;
          ack_cnt++;
          if (mem_we) begin
            wr_cnt++;
            wr_addr = mem_addr;
          end
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
    if (acc_ld) begin
      ld_cnt++;
      ld_alus = alus;
      ld_opnd = opnd;
      ld_pc = pc;
    end
    if (mem_req) req_cycles++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic prog_clear();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    run = 1'b0;
    wait_cycles = 0;
    repeat (2) tick();
    ack_cnt = 0;
    wr_cnt = 0;
    ld_cnt = 0;
    req_cycles = 0;
    for (int i = 0; i < 3; i++) ack_hist[i] = 8'h00;
  endtask

  // kind: 0 = acc_ld count reaches n, 1 = request at address a, 2 = halted, 3 = write request, 4 = ack count reaches n
  task automatic wait_for(input int kind, input int n, input logic [7:0] a, input string tag);
    int  k = 0;
    bit  hit = 1'b0;
    while (!hit && k < 3000) begin
      case (kind)
        0: hit = (ld_cnt >= n);
        1: hit = (mem_req === 1'b1 && mem_addr === a);
        2: hit = (halted === 1'b1);
        3: hit = (mem_we === 1'b1);
        default: hit = (ack_cnt >= n);
      endcase
      if (!hit) begin
        tick();
        k++;
      end
    end
    check({tag, "_wait"}, 32'(hit), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int cnt;

    // ADD immediate with two wait states, then HALT and reset out of it
    prog_clear();
    mem[8'h00] = 8'h10; mem[8'h01] = 8'h05; mem[8'h02] = 8'hF0;
    do_reset();
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_acc_ld", 32'(acc_ld), 32'd0);
    check("rst_alus", 32'(alus), 32'd0);
    check("rst_pc", 32'(pc), 32'h00);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_opnd", 32'(opnd), 32'h00);
    check("rst_mem_addr", 32'(mem_addr), 32'h00);
    wait_cycles = 2;
    run = 1'b1;
    rst_n = 1'b1;
    wait_for(0, 1, 8'h00, "add_ld");
    check("add_alus", 32'(ld_alus), 32'h1);
    check("add_opnd", 32'(ld_opnd), 32'h05);
    check("add_pc", 32'(ld_pc), 32'h02);
    check("add_addr0", 32'(ack_hist[1]), 32'h00);
    check("add_addr1", 32'(ack_hist[0]), 32'h01);
    wait_for(1, 0, 8'h02, "add_next_fetch");
    check("add_next_we", 32'(mem_we), 32'd0);
    wait_for(2, 0, 8'h00, "halt");
    req_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      run = i[0];
      tick();
    end
    check("halt_no_req", 32'(req_cycles), 32'd0);
    check("halt_stays", 32'(halted), 32'd1);
    check("halt_ld_count", 32'(ld_cnt), 32'd1);
    check("halt_pc", 32'(pc), 32'h03);
    rst_n = 1'b0;
    #1;
    check("halt_rst_pc", 32'(pc), 32'h00);
    check("halt_rst_halted", 32'(halted), 32'd0);

    // INC at 0x10 with zero-wait memory: three-cycle instruction, opnd untouched
    prog_clear();
    mem[8'h0E] = 8'h10; mem[8'h0F] = 8'h33; mem[8'h10] = 8'h60; mem[8'h11] = 8'hF0;
    do_reset();
    run = 1'b1;
    rst_n = 1'b1;
    wait_for(1, 0, 8'h10, "inc_fetch");
    tick();
    check("inc_decode_ld", 32'(acc_ld), 32'd0);
    tick();
    check("inc_exec_ld", 32'(acc_ld), 32'd1);
    check("inc_alus", 32'(alus), 32'h6);
    check("inc_opnd", 32'(opnd), 32'h33);
    check("inc_pc", 32'(pc), 32'h11);
    tick();
    check("inc_after_ld", 32'(acc_ld), 32'd0);
    check("inc_next_req", 32'(mem_req), 32'd1);
    check("inc_next_addr", 32'(mem_addr), 32'h11);
    wait_for(2, 0, 8'h00, "inc_halt");
    check("inc_ld_count", 32'(ld_cnt), 32'd2);

    // STA 0x40 with one wait state: write held until ack, no accumulator load
    prog_clear();
    mem[8'h00] = 8'hB0; mem[8'h01] = 8'h40; mem[8'h02] = 8'hF0;
    do_reset();
    wait_cycles = 1;
    run = 1'b1;
    rst_n = 1'b1;
    wait_for(3, 0, 8'h00, "sta_we");
    check("sta_addr", 32'(mem_addr), 32'h40);
    check("sta_req", 32'(mem_req), 32'd1);
    cnt = 0;
    while (mem_we === 1'b1 && cnt < 10) begin
      cnt++;
      tick();
    end
    check("sta_we_cycles", 32'(cnt), 32'd2);
    wait_for(2, 0, 8'h00, "sta_halt");
    check("sta_wr_count", 32'(wr_cnt), 32'd1);
    check("sta_wr_addr", 32'(wr_addr), 32'h40);
    check("sta_ld_count", 32'(ld_cnt), 32'd0);
    check("sta_operand_read", 32'(ack_hist[2]), 32'h01);

    // LDI at 0xFF with operand at 0x00: pc wraps
    prog_clear();
    mem[8'h00] = 8'h7E; mem[8'hFF] = 8'h90;
    do_reset();
    run = 1'b1;
    rst_n = 1'b1;
    wait_for(0, 2, 8'h00, "wrap_ld");
    run = 1'b0;
    check("wrap_alus", 32'(ld_alus), 32'h9);
    check("wrap_opnd", 32'(ld_opnd), 32'h7E);
    check("wrap_pc", 32'(ld_pc), 32'h01);
    check("wrap_op_addr", 32'(ack_hist[1]), 32'hFF);
    check("wrap_oper_addr", 32'(ack_hist[0]), 32'h00);
    repeat (3) tick();
    check("wrap_idle_req", 32'(mem_req), 32'd0);
    check("wrap_idle_pc", 32'(pc), 32'h01);

    // Illegal opcode 0xD0
    prog_clear();
    mem[8'h00] = 8'hD0; mem[8'h01] = 8'hF0;
    do_reset();
    run = 1'b1;
    rst_n = 1'b1;
    wait_for(2, 0, 8'h00, "ill_halt");
`ifdef ILLEGAL_TRAP_EN
    check("ill_flag", 32'(illegal), 32'd1);
    check("ill_acks", 32'(ack_cnt), 32'd1);
    check("ill_pc", 32'(pc), 32'h01);
`else
    check("ill_flag", 32'(illegal), 32'd0);
    check("ill_acks", 32'(ack_cnt), 32'd2);
    check("ill_pc", 32'(pc), 32'h02);
`endif
    check("ill_ld_count", 32'(ld_cnt), 32'd0);

    // Reset asserted during an OPER wait abandons the transfer at once
    prog_clear();
    mem[8'h00] = 8'h10; mem[8'h01] = 8'h22;
    do_reset();
    wait_cycles = 5;
    run = 1'b1;
    rst_n = 1'b1;
    wait_for(4, 1, 8'h00, "oper_first_ack");
    wait_for(1, 0, 8'h01, "oper_req");
    repeat (2) tick();
    check("oper_waiting", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check("oper_rst_req", 32'(mem_req), 32'd0);
    check("oper_rst_pc", 32'(pc), 32'h00);
    check("oper_rst_addr", 32'(mem_addr), 32'h00);
    tick();
    wait_cycles = 0;
    ld_cnt = 0;
    rst_n = 1'b1;
    wait_for(1, 0, 8'h00, "oper_refetch");
    check("oper_refetch_we", 32'(mem_we), 32'd0);
    wait_for(0, 1, 8'h00, "oper_refetch_ld");
    check("oper_refetch_opnd", 32'(ld_opnd), 32'h22);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Fetch/decode/execute control FSM for the 8-bit CPU; sits directly upstream of the ALU.
- Fetches instruction and immediate-operand bytes over a req/ack memory port.
- Drives the ALU operation code and the operand byte on the ALU bus input, then pulses the accumulator load that captures ALU output into x.
- Issues accumulator store cycles.

Parameters:
- RESET_PC, 8'h00, PC value loaded on reset.
- ADDR_W, 8, PC and memory address width; PC wraps modulo 2^ADDR_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- run  input  1  permits a new instruction fetch when high.
- mem_req  output  1  memory request; held until the ack cycle.
- mem_we  output  1  1 = write (accumulator to mem_addr); valid with mem_req.
- mem_addr  output  ADDR_W  request address.
- mem_ack  input  1  transfer completes in any cycle where mem_req && mem_ack.
- mem_rdata  input  8  read data; valid in the ack cycle.
- opnd  output  8  latched operand byte, drives the ALU bus input.
- alus  output  4  ALU operation code.
- acc_ld  output  1  one-cycle pulse; accumulator (ALU x input) loads ALU dout.
- pc  output  ADDR_W  program counter.
- halted  output  1  high in HALT state.
- illegal  output  1  sticky illegal-opcode flag.

Behaviour:
- Reset (async, immediate) values:
  - state=FETCH, pc=RESET_PC, ir=0, opnd=0, addr register=0.
  - mem_req=0, mem_we=0, acc_ld=0, alus=4'b0000, halted=0, illegal=0.
  - Any pending memory transfer is abandoned.
- All outputs decode from registers only; there is no combinational path from inputs to outputs.
- Instruction byte: opcode=ir[7:4]; ir[3:0] is ignored.
  - Binary immediate (two bytes): 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 9 LDI.
  - Unary (one byte): 6 INC, 7 DEC, 8 SHR, A NEG, C CLR.
  - Control: 0 NOP, B STA (two bytes; second byte is the address), F HALT.
  - D, E are illegal.
- alus in EXEC: opcode value for 1..A, 4'b0000 for CLR. alus=4'b0000 in every other state.
- FETCH: mem_req=run, mem_we=0, mem_addr=pc.
  - On ack: ir<=mem_rdata, pc<=pc+1, go to DECODE.
  - run low means idle in FETCH; run is ignored once an instruction has started.
- DECODE (1 cycle):
  - binary or STA -> OPER.
  - unary -> EXEC.
  - NOP -> FETCH.
  - HALT -> HALT.
  - illegal -> see Optional Feature.
- OPER: mem_req=1, mem_addr=pc.
  - On ack: opnd<=mem_rdata (binary ops) or addr<=mem_rdata (STA), pc<=pc+1.
  - Then binary -> EXEC, STA -> STORE.
- EXEC (1 cycle): acc_ld=1, alus per opcode, opnd held stable; then -> FETCH.
- STORE: mem_req=1, mem_we=1, mem_addr=addr; on ack -> FETCH.
- HALT: absorbing; only rst_n exits it. halted=1, mem_req=0.
- mem_req drops in the cycle after ack, because the state changes. Zero-wait ack gives these instruction latencies:
  - unary: 3 cycles.
  - binary: 4 cycles.
  - STA: 4 cycles.
  - NOP: 2 cycles.
  - Each wait cycle adds 1.
- pc increments modulo 2^ADDR_W: 8'hFF -> 8'h00. An operand fetched at 8'h00 after an opcode at 8'hFF is legal.
- acc_ld never asserts outside EXEC; NOP never loads the accumulator.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined: an illegal opcode in DECODE sets illegal=1 and goes to HALT.
- Undefined: an illegal opcode executes as NOP (-> FETCH); illegal stays 0 permanently.

Decomposition:
- Shared package cpu_pkg holds:
  - 4-bit opcode constants (OP_NOP..OP_HALT).
  - ALU operation code constants (ALU_ZERO, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_INC, ALU_DEC, ALU_SHR, ALU_PASS, ALU_NEG).
  - FSM state enum (FETCH, DECODE, OPER, EXEC, STORE, HALT).
- One sub-module, seq_decode: combinational opcode -> {class, alu code, is_illegal}. The FSM and registers stay in alu_sequencer.

Test Plan:
- Reset, then run=1 with memory {00:0x10, 01:0x05} and ack after 2 wait cycles.
  -> mem_addr 00 then 01, opnd=0x05, one acc_ld pulse with alus=4'b0001, pc=02, next fetch at 02.
- INC (0x60) at pc=0x10 with zero-wait ack.
  -> acc_ld exactly one cycle with alus=4'b0110, opnd unchanged, pc=0x11, 3 cycles total.
- STA (0xB0, 0x40).
  -> read at pc, read at pc+1, then mem_we=1 at mem_addr=0x40 until ack; no acc_ld.
- Opcode 0x90 at pc=0xFF, operand 0x7E at 0x00.
  -> pc wraps to 0x00 then 0x01; alus=4'b1001, opnd=0x7E.
- Byte 0xF0.
  -> halted=1, mem_req stays 0 for 20 cycles regardless of run. Assert rst_n low -> pc=RESET_PC, halted=0.
- Byte 0xD0 with ILLEGAL_TRAP_EN -> illegal=1, halted=1. Without the macro -> next fetch at pc+1, illegal=0. Separately, drop rst_n during an OPER wait -> mem_req=0 immediately, state=FETCH.
